// File: rtl/point_double_ld_param_pkg.sv
// Shared types and constants for the Lopez-Dahab doubler: state encoding,
// sect233 field/curve constants and the end-to-end latency helper.
package ecc_ld_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SQR,
        MUL_Z,
        MUL_BZ,
        MUL_L,
        MUL_Y,
        DONE
    } ld_state_e;

    localparam int SECT233_M = 233;

    // x^233 + x^74 + 1 with the leading x^233 term dropped
    localparam logic [SECT233_M-1:0] SECT233_POLY = (233'd1 << 74) | 233'd1;

    localparam logic [SECT233_M-1:0] SECT233R1_B =
        233'h66_647EDE6C_332C7F8C_0923BB58_213B333B_20E9CE42_81FE115F_7D8F90AD;
    localparam logic [SECT233_M-1:0] SECT233K1_B = 233'd1;

    // Cycles from the accept edge to the edge after which done is high
    function automatic int ld_dbl_latency(input int mult_lat);
        return 6 + 4 * (mult_lat + 1);
    endfunction

endpackage

// File: rtl/point_double_ld_param_if.sv
// Handshake and coordinate bus of the LD point doubler.
// The err line exists only when LD_DBL_ERR_EN is defined.
interface point_double_ld_param_if #(
    parameter int M = 233
);
    logic         start;
    logic [M-1:0] X1;
    logic [M-1:0] Y1;
    logic [M-1:0] Z1;
    logic         busy;
    logic         done;
    logic [M-1:0] X2;
    logic [M-1:0] Y2;
    logic [M-1:0] Z2;
`ifdef LD_DBL_ERR_EN
    logic         err;

    modport master (output start, X1, Y1, Z1, input busy, done, X2, Y2, Z2, err);
    modport slave  (input start, X1, Y1, Z1, output busy, done, X2, Y2, Z2, err);
`else
    modport master (output start, X1, Y1, Z1, input busy, done, X2, Y2, Z2);
    modport slave  (input start, X1, Y1, Z1, output busy, done, X2, Y2, Z2);
`endif
endinterface

// File: rtl/gf2m_mul_pipe.sv
// Shared pipelined GF(2^M) multiplier: full product in the first stage,
// then LAT-1 delay stages, so p reflects a/b after LAT clock edges.
module gf2m_mul_pipe #(
    parameter int           M    = 233,
    parameter logic [M-1:0] POLY = '0,
    parameter int           LAT  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);
    logic [M-1:0] stage_q [LAT];

    // MSB-first shift-and-add with interleaved reduction
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] r;
        r = '0;
        for (int i = M-1; i >= 0; i--) begin
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY : '0);
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    // Product pipeline, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= gf_mul(a, b);
            for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign p = stage_q[LAT-1];
endmodule

// File: rtl/gf2m_sqr_param.sv
// Combinational GF(2^M) squarer: interleave zeros, then fold the upper
// half back down using x^M = POLY.
module gf2m_sqr_param #(
    parameter int           M    = 233,
    parameter logic [M-1:0] POLY = '0
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] sq
);
    logic [2*M-1:0] spread;
    logic [2*M-1:0] red;

    for (genvar gi = 0; gi < M; gi++) begin : g_spread
        assign spread[2*gi]   = a[gi];
        assign spread[2*gi+1] = 1'b0;
    end

    // Reduce from the top bit down so each fold only touches lower bits
    always_comb begin
        red = spread;
        for (int i = 2*M-2; i >= M; i--) begin
            if (red[i]) begin
                red[i]         = 1'b0;
                red[i-M +: M]  = red[i-M +: M] ^ POLY;
            end
        end
    end

    assign sq = red[M-1:0];
endmodule

// File: rtl/point_double_ld_param.sv
// Lopez-Dahab point doubler over GF(2^M), one shared squarer and one shared
// pipelined multiplier. Optional sticky misuse flag: define LD_DBL_ERR_EN.
module point_double_ld_param
    import ecc_ld_pkg::*;
#(
    parameter int           M        = 233,
    parameter logic [M-1:0] POLY     = SECT233_POLY,
    parameter logic [M-1:0] B_CURVE  = SECT233R1_B,
    parameter int           A_COEF   = 1,
    parameter int           MULT_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    point_double_ld_param_if.slave bus
);
    if (A_COEF != 0 && A_COEF != 1) begin : g_bad_a
        $error("A_COEF must be 0 or 1");
    end
    if (MULT_LAT < 1 || MULT_LAT > 15) begin : g_bad_lat
        $error("MULT_LAT must be 1..15");
    end

    localparam logic [3:0] LAT_END = 4'(MULT_LAT);
    localparam logic       A_ON    = (A_COEF == 1);

    ld_state_e    state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_q, done_d;
    logic [M-1:0] x1_q, x1_d, y1_q, y1_d, z1_q, z1_d;
    logic [M-1:0] t_x2_q, t_x2_d, t_z2_q, t_z2_d, t_z4_q, t_z4_d;
    logic [M-1:0] t_x4_q, t_x4_d, t_y2_q, t_y2_d;
    logic [M-1:0] bz4_q, bz4_d, l_q, l_d;
    logic [M-1:0] x2_q, x2_d, y2_q, y2_d, z2_q, z2_d;
    logic [M-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [M-1:0] sqr_in, sqr_out, mul_p;
    logic         busy;

    gf2m_sqr_param #(.M(M), .POLY(POLY)) u_sqr (.a(sqr_in), .sq(sqr_out));

    gf2m_mul_pipe #(.M(M), .POLY(POLY), .LAT(MULT_LAT)) u_mul (
        .clk(clk), .rst_n(rst_n), .a(mul_a_q), .b(mul_b_q), .p(mul_p)
    );

    assign busy     = (state_q != IDLE);
    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.X2   = x2_q;
    assign bus.Y2   = y2_q;
    assign bus.Z2   = z2_q;

    // Squarer input order: X1, Z1, Z1^2, X1^2, Y1
    always_comb begin
        case (cnt_q)
            4'd0:    sqr_in = x1_q;
            4'd1:    sqr_in = z1_q;
            4'd2:    sqr_in = t_z2_q;
            4'd3:    sqr_in = t_x2_q;
            default: sqr_in = y1_q;
        endcase
    end

    // Sequencer: squarings, then Z2, b*Z1^4 (and X2), L, Y2
    always_comb begin
        state_d = state_q;  cnt_d  = cnt_q;  done_d = 1'b0;
        x1_d = x1_q;  y1_d = y1_q;  z1_d = z1_q;
        t_x2_d = t_x2_q;  t_z2_d = t_z2_q;  t_z4_d = t_z4_q;
        t_x4_d = t_x4_q;  t_y2_d = t_y2_q;  bz4_d = bz4_q;  l_d = l_q;
        x2_d = x2_q;  y2_d = y2_q;  z2_d = z2_q;
        mul_a_d = mul_a_q;  mul_b_d = mul_b_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x1_d  = bus.X1;  y1_d = bus.Y1;  z1_d = bus.Z1;
                    cnt_d = '0;
                    if (bus.Z1 == '0) begin
                        // Point at infinity doubles to itself (1:0:0)
                        x2_d = M'(1);  y2_d = '0;  z2_d = '0;
                        state_d = DONE;
                    end else begin
                        state_d = SQR;
                    end
                end
            end
            SQR: begin
                case (cnt_q)
                    4'd0:    t_x2_d = sqr_out;
                    4'd1:    t_z2_d = sqr_out;
                    4'd2:    t_z4_d = sqr_out;
                    4'd3:    t_x4_d = sqr_out;
                    default: t_y2_d = sqr_out;
                endcase
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd4) begin
                    cnt_d   = '0;
                    mul_a_d = t_x2_q;
                    mul_b_d = t_z2_q;
                    state_d = MUL_Z;
                end
            end
            MUL_Z, MUL_BZ, MUL_L, MUL_Y: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAT_END) begin
                    cnt_d = '0;
                    case (state_q)
                        MUL_Z: begin
                            z2_d    = mul_p;
                            mul_a_d = B_CURVE;
                            mul_b_d = t_z4_q;
                            state_d = MUL_BZ;
                        end
                        MUL_BZ: begin
                            bz4_d   = mul_p;
                            x2_d    = t_x4_q ^ mul_p;
                            mul_a_d = t_x4_q ^ mul_p;
                            mul_b_d = ({M{A_ON}} & z2_q) ^ t_y2_q ^ mul_p;
                            state_d = MUL_L;
                        end
                        MUL_L: begin
                            l_d     = mul_p;
                            mul_a_d = bz4_q;
                            mul_b_d = z2_q;
                            state_d = MUL_Y;
                        end
                        default: begin
                            y2_d    = mul_p ^ l_q;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;  cnt_q <= '0;  done_q <= 1'b0;
            x1_q <= '0;  y1_q <= '0;  z1_q <= '0;
            t_x2_q <= '0;  t_z2_q <= '0;  t_z4_q <= '0;  t_x4_q <= '0;  t_y2_q <= '0;
            bz4_q <= '0;  l_q <= '0;  x2_q <= '0;  y2_q <= '0;  z2_q <= '0;
            mul_a_q <= '0;  mul_b_q <= '0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  done_q <= done_d;
            x1_q <= x1_d;  y1_q <= y1_d;  z1_q <= z1_d;
            t_x2_q <= t_x2_d;  t_z2_q <= t_z2_d;  t_z4_q <= t_z4_d;
            t_x4_q <= t_x4_d;  t_y2_q <= t_y2_d;
            bz4_q <= bz4_d;  l_q <= l_d;  x2_q <= x2_d;  y2_q <= y2_d;  z2_q <= z2_d;
            mul_a_q <= mul_a_d;  mul_b_q <= mul_b_d;
        end
    end

`ifdef LD_DBL_ERR_EN
    logic err_q, err_d;

    // Sticky flag for a start request that arrives while busy
    always_comb begin
        err_d = err_q | (bus.start & busy);
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_point_double_ld_param.sv
// Directed bench for point_double_ld_param: four instances with different
// A_COEF / MULT_LAT, expected values from an independent GF(2^233) model.
module tb_point_double_ld_param;
    import ecc_ld_pkg::*;

    localparam int           M    = 233;
    localparam logic [M-1:0] POLY = SECT233_POLY;
    localparam logic [M-1:0] B    = SECT233R1_B;
    localparam logic [M-1:0] GX   =
        233'hFA_C9DFCBAC_8313BB21_39F1BB75_5FEF65BC_391F8B36_F8F8EB73_71FD558B;
    localparam logic [M-1:0] GY   =
        233'h100_6A08A419_03350678_E58528BE_BF8A0BEF_F867A7CA_36716F7E_01F81052;
    localparam logic [M-1:0] ONE  = M'(1);

    // instance: 0 -> a=1,L=3   1 -> a=0,L=3   2 -> a=1,L=1   3 -> a=1,L=5
    localparam logic [3:0]  A_TBL   = 4'b1101;
    localparam logic [15:0] LAT_TBL = 16'h5133;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         start_v [4];
    logic [M-1:0] x1_v [4], y1_v [4], z1_v [4];
    logic         busy_v [4], done_v [4];
    logic [M-1:0] x2_v [4], y2_v [4], z2_v [4];
`ifdef LD_DBL_ERR_EN
    logic         err_v [4];
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        point_double_ld_param_if #(.M(M)) bus ();
        point_double_ld_param #(
            .M(M), .POLY(POLY), .B_CURVE(B),
            .A_COEF(int'(A_TBL[gi])), .MULT_LAT(int'(LAT_TBL[4*gi +: 4]))
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );
        assign bus.start  = start_v[gi];
        assign bus.X1     = x1_v[gi];
        assign bus.Y1     = y1_v[gi];
        assign bus.Z1     = z1_v[gi];
        assign busy_v[gi] = bus.busy;
        assign done_v[gi] = bus.done;
        assign x2_v[gi]   = bus.X2;
        assign y2_v[gi]   = bus.Y2;
        assign z2_v[gi]   = bus.Z2;
`ifdef LD_DBL_ERR_EN
        assign err_v[gi]  = bus.err;
`endif
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference arithmetic: LSB-first multiply, Fermat inversion
    function automatic logic [M-1:0] m_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r, aa;
        r = '0;  aa = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[M-1] ? ({aa[M-2:0], 1'b0} ^ POLY) : {aa[M-2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [M-1:0] m_inv(input logic [M-1:0] a);
        logic [M-1:0] t;
        t = a;
        for (int i = 1; i <= M-2; i++) t = m_mul(m_mul(t, t), a);
        return m_mul(t, t);
    endfunction

    function automatic logic [M-1:0] rand_fe();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r[M-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble inputs, count cycles and busy samples to done
    task automatic run_op(input int idx, input logic [M-1:0] x, input logic [M-1:0] y,
                          input logic [M-1:0] z, output int cyc, output int busy_n);
        start_v[idx] = 1'b1;
        x1_v[idx] = x;  y1_v[idx] = y;  z1_v[idx] = z;
        tick();
        start_v[idx] = 1'b0;
        x1_v[idx] = rand_fe();  y1_v[idx] = rand_fe();  z1_v[idx] = rand_fe();
        cyc = 0;
        busy_n = busy_v[idx] ? 1 : 0;
        while (!done_v[idx] && cyc < 200) begin
            tick();
            cyc++;
            if (busy_v[idx]) busy_n++;
        end
        $display("op dut%0d cycles=%0d X2=%h", idx, cyc, x2_v[idx]);
    endtask

    logic [M-1:0] b_sq, lam, ax3, ay3, z2_exp;
    int           cyc, busy_n, t_now, na, nd;
    int           acc [2];
    int           dn [2];
    logic         done_seen, prev_busy;

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;  x1_v[i] = '0;  y1_v[i] = '0;  z1_v[i] = '0;
        end
        b_sq = m_mul(B, B);
        lam  = GX ^ m_mul(GY, m_inv(GX));
        ax3  = m_mul(lam, lam) ^ lam ^ ONE;
        ay3  = m_mul(GX, GX) ^ m_mul(lam ^ ONE, ax3);

        // Reset state
        rst_n = 1'b0;
        tick();  tick();
        chk_b("rst_busy", busy_v[0], 1'b0);
        chk_b("rst_done", done_v[0], 1'b0);
        chk_v("rst_x2", x2_v[0], '0);
        chk_v("rst_y2", y2_v[0], '0);
        chk_v("rst_z2", z2_v[0], '0);
        rst_n = 1'b1;
        tick();

        // Point at infinity
        run_op(0, M'(5), M'(7), '0, cyc, busy_n);
        chk_i("inf_cycles", cyc, 1);
        chk_i("inf_busy_cycles", busy_n, 1);
        chk_v("inf_x2", x2_v[0], ONE);
        chk_v("inf_y2", y2_v[0], '0);
        chk_v("inf_z2", z2_v[0], '0);
        tick();
        chk_b("inf_done_pulse", done_v[0], 1'b0);

        // (1:1:1), a=1, latency 3
        run_op(0, ONE, ONE, ONE, cyc, busy_n);
        chk_i("one_a1_cycles", cyc, 22);
        chk_i("one_a1_busy_cycles", busy_n, 22);
        chk_v("one_a1_z2", z2_v[0], ONE);
        chk_v("one_a1_x2", x2_v[0], ONE ^ B);
        chk_v("one_a1_y2", y2_v[0], b_sq);

        // (1:1:1), a=0, latency 3
        run_op(1, ONE, ONE, ONE, cyc, busy_n);
        chk_i("one_a0_cycles", cyc, 22);
        chk_v("one_a0_z2", z2_v[1], ONE);
        chk_v("one_a0_x2", x2_v[1], ONE ^ B);
        chk_v("one_a0_y2", y2_v[1], b_sq ^ B ^ ONE);

        // Generator, latency 1 and 5, compared against affine 2G
        z2_exp = m_mul(GX, GX);
        run_op(2, GX, GY, ONE, cyc, busy_n);
        chk_i("gen_l1_cycles", cyc, 14);
        chk_v("gen_l1_z2", z2_v[2], z2_exp);
        chk_v("gen_l1_x_affine", x2_v[2], m_mul(ax3, z2_exp));
        chk_v("gen_l1_y_affine", y2_v[2], m_mul(ay3, m_mul(z2_exp, z2_exp)));
        run_op(3, GX, GY, ONE, cyc, busy_n);
        chk_i("gen_l5_cycles", cyc, 30);
        chk_v("gen_l5_z2", z2_v[3], z2_exp);
        chk_v("gen_l5_x_affine", x2_v[3], m_mul(ax3, z2_exp));
        chk_v("gen_l5_y_affine", y2_v[3], m_mul(ay3, m_mul(z2_exp, z2_exp)));

        // Reset during an operation
        start_v[0] = 1'b1;  x1_v[0] = ONE;  y1_v[0] = ONE;  z1_v[0] = ONE;
        tick();
        start_v[0] = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_v[0]) done_seen = 1'b1;
        end
        rst_n = 1'b0;
        tick();
        chk_b("abort_no_done", done_seen, 1'b0);
        chk_b("abort_busy", busy_v[0], 1'b0);
        chk_b("abort_done", done_v[0], 1'b0);
        chk_v("abort_x2", x2_v[0], '0);
        chk_v("abort_y2", y2_v[0], '0);
        chk_v("abort_z2", z2_v[0], '0);
        rst_n = 1'b1;
        tick();
        run_op(0, ONE, ONE, ONE, cyc, busy_n);
        chk_i("after_abort_cycles", cyc, 22);
        chk_v("after_abort_y2", y2_v[0], b_sq);

        // start held high: back-to-back operations
        start_v[0] = 1'b1;  x1_v[0] = ONE;  y1_v[0] = ONE;  z1_v[0] = ONE;
        na = 0;  nd = 0;  prev_busy = busy_v[0];
        acc[0] = -1000;  acc[1] = -1000;  dn[0] = -1000;  dn[1] = -1000;
        for (t_now = 0; t_now < 60 && nd < 2; t_now++) begin
            tick();
            if (busy_v[0] && !prev_busy && na < 2) begin
                acc[na] = t_now;
                na++;
            end
            if (done_v[0] && nd < 2) begin
                dn[nd] = t_now;
                nd++;
                if (nd == 2) chk_v("b2b_y2", y2_v[0], b_sq);
            end
`ifdef LD_DBL_ERR_EN
            if (na == 1 && t_now == acc[0])     chk_b("err_first_busy", err_v[0], 1'b0);
            if (na >= 1 && t_now == acc[0] + 1) chk_b("err_second_busy", err_v[0], 1'b1);
`endif
            prev_busy = busy_v[0];
        end
        start_v[0] = 1'b0;
        $display("b2b accepts=%0d,%0d dones=%0d,%0d", acc[0], acc[1], dn[0], dn[1]);
        chk_i("b2b_lat1", dn[0] - acc[0], 22);
        chk_i("b2b_accept_gap", acc[1] - acc[0], 23);
        chk_i("b2b_lat2", dn[1] - acc[1], 22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
